// File: rtl/fetch_unit_if.sv
// Fetch bus between the fetch unit, the instruction ROM and decode.
//   pc_out         : address presented to the ROM this cycle
//   code_in        : registered ROM word for last cycle's pc_out
//   stall          : decode cannot accept instr_out this cycle
//   redirect_valid : branch/jump/exception redirect request
//   redirect_pc    : redirect target address
//   instr_out      : instruction to decode
//   instr_pc       : address of instr_out
//   instr_valid    : instr_out/instr_pc meaningful
//   exc_adel       : instr_pc misaligned or outside the text segment
// master = fetch unit side, slave = ROM/decode/control side.
interface fetch_unit_if;
    logic [31:0] pc_out;
    logic [31:0] code_in;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        exc_adel;

    modport master (
        output pc_out, instr_out, instr_pc, instr_valid, exc_adel,
        input  code_in, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  pc_out, instr_out, instr_pc, instr_valid, exc_adel,
        output code_in, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a registered instruction ROM.
// Keeps one fetch in flight, holds the returned word while decode stalls,
// and lets redirects override stalls, squashing the in-flight word.
// Ports:
//   clk     : single clock
//   reset_n : synchronous active-low reset
//   bus     : fetch_unit_if.master (ROM address/data, decode handshake,
//             redirect request, instruction and fault outputs)
module fetch_unit #(
    parameter logic [31:0] TEXT_START = 32'h0000_3000,
    parameter logic [31:0] IM_SIZE    = 32'h0000_4000
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);

    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic [31:0] hold_instr;
    logic        hold_valid;
    logic        exc_adel;

    // 33-bit end bound so a segment ending at 2^32 does not wrap to zero.
    logic [32:0] text_end;
    assign text_end = {1'b0, TEXT_START} + {1'b0, IM_SIZE};

    assign exc_adel = resp_valid &&
                      ((resp_pc[1:0] != 2'b00) ||
                       (resp_pc < TEXT_START) ||
                       ({1'b0, resp_pc} >= text_end));

    always_comb begin
        bus.pc_out      = bus.redirect_valid ? bus.redirect_pc : fetch_pc;
        bus.instr_valid = resp_valid && !bus.redirect_valid;
        bus.instr_pc    = resp_pc;
        bus.exc_adel    = exc_adel;
        bus.instr_out   = hold_valid ? hold_instr : bus.code_in;
        if (exc_adel) begin
            bus.instr_out = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc   <= TEXT_START;
            resp_pc    <= TEXT_START;
            resp_valid <= 1'b0;
            hold_valid <= 1'b0;
            hold_instr <= 32'h0;
        end else if (bus.redirect_valid) begin
            // The address on the ROM this cycle is redirect_pc itself.
            fetch_pc   <= bus.redirect_pc + 32'd4;
            resp_pc    <= bus.redirect_pc;
            resp_valid <= 1'b1;
            hold_valid <= 1'b0;
        end else if (!bus.stall) begin
            fetch_pc   <= fetch_pc + 32'd4;
            resp_pc    <= fetch_pc;
            resp_valid <= 1'b1;
            hold_valid <= 1'b0;
        end else if (resp_valid && !hold_valid) begin
            // ROM output moves on next cycle (pc_out is re-presented), so
            // capture the word decode has not taken yet.
            hold_instr <= bus.code_in;
            hold_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] TEXT_START = 32'h0000_3000;
    localparam logic [31:0] TEXT_END   = 32'h0000_7000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    logic clk;
    logic reset_n;
    fetch_unit_if bus ();

    int checks = 0;
    int errors = 0;

    exp_t        sb_q[$];
    logic [31:0] exp_fetch;

    fetch_unit #(
        .TEXT_START (32'h0000_3000),
        .IM_SIZE    (32'h0000_4000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        if (addr == 32'h0000_3000) return 32'h2401_0001;
        if (addr == 32'h0000_3004) return 32'h2402_0002;
        return {~addr[15:0], addr[15:0]};
    endfunction

    function automatic exp_t make_exp(input logic [31:0] addr);
        exp_t e;
        e.pc    = addr;
        e.exc   = (addr[1:0] != 2'b00) || (addr < TEXT_START) || (addr >= TEXT_END);
        e.instr = e.exc ? 32'h0 : rom_word(addr);
        return e;
    endfunction

    // Registered ROM: word for this cycle's pc_out appears next cycle.
    always @(posedge clk) bus.code_in <= rom_word(bus.pc_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after negedge, check outputs, update the
    // scoreboard for what the coming posedge issues/consumes.
    task automatic step(input logic st, input logic rv, input logic [31:0] rp, input logic rst);
        exp_t e;
        logic exp_valid;
        @(negedge clk);
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        reset_n            = !rst;
        #1;
        if (rst) begin
            sb_q.delete();
            exp_fetch = TEXT_START;
        end else begin
            chk("pc_out", bus.pc_out, rv ? rp : exp_fetch);
            exp_valid = !rv && (sb_q.size() != 0);
            chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, exp_valid});
            if (sb_q.size() == 0) begin
                chk("exc_idle", {31'b0, bus.exc_adel}, 32'h0);
            end
            if (exp_valid && bus.instr_valid) begin
                e = sb_q[0];
                chk("instr_pc", bus.instr_pc, e.pc);
                chk("instr_out", bus.instr_out, e.instr);
                chk("exc_adel", {31'b0, bus.exc_adel}, {31'b0, e.exc});
            end
            if (rv) begin
                sb_q.delete();
                sb_q.push_back(make_exp(rp));
                exp_fetch = rp + 32'd4;
            end else if (!st) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                sb_q.push_back(make_exp(exp_fetch));
                exp_fetch = exp_fetch + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] tgt;
        reset_n            = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        exp_fetch          = TEXT_START;

        // reset, then first two instructions
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h5000, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        // stall 3 cycles while 0x3004 is on output, then release
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        // stall, then redirect together with stall
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_4180, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
        // misaligned and out-of-range redirects
        step(1'b0, 1'b1, 32'h0000_3002, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_7000, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_2FFC, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        // last word of the segment, then sequential fall-off into 0x7000
        step(1'b0, 1'b1, 32'h0000_6FF8, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        // reset in the middle of a stall with the hold register full
        step(1'b0, 1'b1, 32'h0000_3400, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        // back-to-back redirects
        step(1'b0, 1'b1, 32'h0000_3100, 1'b0);
        step(1'b0, 1'b1, 32'h0000_3200, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);

        // random stall/redirect traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0: tgt = 32'h0000_2000 + 32'd4 * 32'($urandom_range(0, 32'h17FF));
                    1: tgt = 32'h0000_3000 + 32'($urandom_range(0, 32'h3FFF));
                    2: tgt = 32'h0000_6FF0;
                    default: tgt = 32'h0000_3000 + 32'd4 * 32'($urandom_range(0, 32'hFFF));
                endcase
                step($urandom_range(0, 1) == 1, 1'b1, tgt, 1'b0);
            end else if ($urandom_range(0, 49) == 0) begin
                step($urandom_range(0, 1) == 1, 1'b0, 32'h0, 1'b1);
            end else begin
                step($urandom_range(0, 9) < 3, 1'b0, 32'h0, 1'b0);
            end
        end
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
